// File: rtl/is_uart_tx_param_pkg.sv
// is_pkg_uart_controller: shared types for the UART controller (legacy RX/TX FSM and parametrised TX engine)
package is_pkg_uart_controller;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_mode_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_WCE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    function automatic logic par_enabled(input parity_mode_t m);
        return m == PAR_EVEN || m == PAR_ODD;
    endfunction

endpackage

// File: rtl/is_uart_tx_param.sv
// is_uart_tx_param: UART transmitter, DATA_W bits LSB-first, optional parity, 1/2 stop bits, one-word buffer, CTS
// ports: clk_i/rst_i clock and sync reset; uart_ce_i bit strobe; tx_data_i/tx_valid_i/tx_ready_o word handshake;
//        parity_mode_i/stop2_i frame format; cts_n_i clear-to-send; txd_o line; txct_r_o frame-active (low);
//        tx_busy_o frame in progress; tx_done_o end-of-frame pulse
module is_uart_tx_param
    import is_pkg_uart_controller::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              uart_ce_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [1:0]        parity_mode_i,
    input  logic              stop2_i,
    input  logic              cts_n_i,
    output logic              txd_o,
    output logic              txct_r_o,
    output logic              tx_busy_o,
    output logic              tx_done_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] buf_q, sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              buf_valid_q, accept, can_load, load, frame_end;
    logic              par_q, par_on_q, stop2_q;
    logic              txd_q, txd_d, txct_q, txct_d, busy_q, busy_d, done_q, done_d;
    parity_mode_t      pm;

    assign pm         = parity_mode_t'(parity_mode_i);
    assign accept     = tx_valid_i && !buf_valid_q;
    assign can_load   = buf_valid_q && !cts_n_i;
    assign tx_ready_o = !buf_valid_q;
    assign txd_o      = txd_q;
    assign txct_r_o   = txct_q;
    assign tx_busy_o  = busy_q;
    assign tx_done_o  = done_q;

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        txd_d     = txd_q;
        txct_d    = txct_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load      = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            TX_IDLE: if (can_load) begin
                load    = 1'b1;
                busy_d  = 1'b1;
                state_d = TX_WCE;
            end
            TX_WCE: if (uart_ce_i) begin
                txd_d   = 1'b0;
                txct_d  = 1'b0;
                state_d = TX_START;
            end
            TX_START: if (uart_ce_i) begin
                txd_d   = sh_q[0];
                sh_d    = sh_q >> 1;
                cnt_d   = '0;
                state_d = TX_DATA;
            end
            TX_DATA: if (uart_ce_i) begin
                if (cnt_q == LAST) begin
                    txd_d   = par_on_q ? par_q : 1'b1;
                    state_d = par_on_q ? TX_PARITY : TX_STOP1;
                end else begin
                    txd_d = sh_q[0];
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TX_PARITY: if (uart_ce_i) begin
                txd_d   = 1'b1;
                state_d = TX_STOP1;
            end
            TX_STOP1: if (uart_ce_i) begin
                state_d   = stop2_q ? TX_STOP2 : state_q;
                frame_end = !stop2_q;
            end
            TX_STOP2: frame_end = uart_ce_i;
            default:  state_d = TX_IDLE;
        endcase
        // a buffered word chains straight into its start bit, keeping the line owned
        if (frame_end) begin
            done_d  = 1'b1;
            load    = can_load;
            txd_d   = !can_load;
            txct_d  = !can_load;
            busy_d  = can_load;
            state_d = can_load ? TX_START : TX_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= TX_IDLE;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
            par_q       <= 1'b0;
            par_on_q    <= 1'b0;
            stop2_q     <= 1'b0;
            txd_q       <= 1'b1;
            txct_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            txd_q       <= txd_d;
            txct_q      <= txct_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            buf_valid_q <= load ? 1'b0 : (accept ? 1'b1 : buf_valid_q);
            buf_q       <= accept ? tx_data_i : buf_q;
            sh_q        <= load ? buf_q : sh_d;
            if (load) begin
                par_q    <= ^buf_q ^ (pm == PAR_ODD);
                par_on_q <= par_enabled(pm);
                stop2_q  <= stop2_i;
            end
        end
    end

endmodule

// File: tb/tb_is_uart_tx_param.sv
// tb_is_uart_tx_param: directed vector bench for is_uart_tx_param (DATA_W=8 and DATA_W=7 instances)
module tb_is_uart_tx_param;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  mode;
        logic        stop2;
        logic [31:0] bits;
        int          n;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1, ce = 1'b0;
    logic [7:0] d8 = '0;
    logic [6:0] d7 = '0;
    logic       v8 = 1'b0, v7 = 1'b0, s2 = 1'b0, cts = 1'b0, sel = 1'b0;
    logic [1:0] pm = 2'b00;
    logic       rdy8, txd8, txct8, busy8, done8;
    logic       rdy7, txd7, txct7, busy7, done7;
    logic       rdy_s, txd_s, txct_s, busy_s, done_s;
    int         n_cmp = 0, n_fail = 0, dc8 = 0, dc7 = 0, dc_s;
    vec_t       tv[6];

    is_uart_tx_param #(.DATA_W(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .uart_ce_i(ce), .tx_data_i(d8), .tx_valid_i(v8), .tx_ready_o(rdy8),
        .parity_mode_i(pm), .stop2_i(s2), .cts_n_i(cts), .txd_o(txd8), .txct_r_o(txct8),
        .tx_busy_o(busy8), .tx_done_o(done8)
    );

    is_uart_tx_param #(.DATA_W(7)) dut7 (
        .clk_i(clk), .rst_i(rst), .uart_ce_i(ce), .tx_data_i(d7), .tx_valid_i(v7), .tx_ready_o(rdy7),
        .parity_mode_i(pm), .stop2_i(s2), .cts_n_i(cts), .txd_o(txd7), .txct_r_o(txct7),
        .tx_busy_o(busy7), .tx_done_o(done7)
    );

    always #5 clk = ~clk;

    initial forever begin
        repeat (15) @(posedge clk);
        #1 ce = 1'b1;
        @(posedge clk);
        #1 ce = 1'b0;
    end

    always @(posedge clk) begin
        if (done8) dc8 <= dc8 + 1;
        if (done7) dc7 <= dc7 + 1;
    end

    always_comb begin
        rdy_s  = sel ? rdy7 : rdy8;
        txd_s  = sel ? txd7 : txd8;
        txct_s = sel ? txct7 : txct8;
        busy_s = sel ? busy7 : busy8;
        done_s = sel ? done7 : done8;
        dc_s   = sel ? dc7 : dc8;
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ce();
        bit hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(posedge clk);
            hit = ce;
        end
        if (!hit) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ce_timeout: got no strobe want strobe within 40 cycles");
        end
    endtask

    task automatic send(input logic [7:0] d, input bit keep);
        bit got = 1'b0;
        @(negedge clk);
        if (sel) begin d7 = d[6:0]; v7 = 1'b1; end
        else begin d8 = d; v8 = 1'b1; end
        for (int k = 0; k < 400 && !got; k++) begin
            got = rdy_s;
            if (!got) @(negedge clk);
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=0 want ready=1 within 400 cycles");
        end
        @(posedge clk);
        #1;
        if (!keep) begin v8 = 1'b0; v7 = 1'b0; end
    endtask

    task automatic frame_check(input string nm, input logic [31:0] bits, input int n, input int ndone);
        int dc0;
        @(posedge clk);
        #1 dc0 = dc_s;
        for (int i = 0; i < n; i++) begin
            wait_ce();
            #1;
            chk1($sformatf("%s_bit%0d", nm, i), txd_s, bits[i]);
            chk1($sformatf("%s_txct%0d", nm, i), txct_s, 1'b0);
            chk1($sformatf("%s_busy%0d", nm, i), busy_s, 1'b1);
        end
        wait_ce();
        #1;
        chk1({nm, "_done"}, done_s, 1'b1);
        chk1({nm, "_idle_txd"}, txd_s, 1'b1);
        chk1({nm, "_idle_txct"}, txct_s, 1'b1);
        chk1({nm, "_idle_busy"}, busy_s, 1'b0);
        @(posedge clk);
        #1;
        chk1({nm, "_done_drop"}, done_s, 1'b0);
        chkn({nm, "_done_count"}, dc_s - dc0, ndone);
    endtask

    initial begin
        int dc0, bad;
        tv[0] = '{8'hA5, 2'b00, 1'b0, 32'({1'b1, 8'hA5, 1'b0}), 10};
        tv[1] = '{8'hA5, 2'b10, 1'b1, 32'({2'b11, 1'b1, 8'hA5, 1'b0}), 12};
        tv[2] = '{8'hA5, 2'b01, 1'b0, 32'({1'b1, 1'b0, 8'hA5, 1'b0}), 11};
        tv[3] = '{8'hFF, 2'b10, 1'b0, 32'({1'b1, 1'b1, 8'hFF, 1'b0}), 11};
        tv[4] = '{8'h3C, 2'b11, 1'b0, 32'({1'b1, 8'h3C, 1'b0}), 10};
        tv[5] = '{8'h01, 2'b01, 1'b1, 32'({2'b11, 1'b1, 8'h01, 1'b0}), 12};

        repeat (3) @(posedge clk);
        #1;
        chk1("rst_txd", txd8, 1'b1);
        chk1("rst_txct", txct8, 1'b1);
        chk1("rst_busy", busy8, 1'b0);
        chk1("rst_done", done8, 1'b0);
        chk1("rst_ready", rdy8, 1'b1);
        chk1("rst_txd7", txd7, 1'b1);
        chk1("rst_ready7", rdy7, 1'b1);
        @(negedge clk) rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            pm = tv[v].mode;
            s2 = tv[v].stop2;
            send(tv[v].data, 1'b0);
            fork
                frame_check($sformatf("vec%0d", v), tv[v].bits, tv[v].n, 1);
                begin
                    repeat (30) @(posedge clk);
                    #1;
                    pm = ~pm;
                    s2 = ~s2;
                end
            join
        end

        sel = 1'b1;
        pm = 2'b01;
        s2 = 1'b0;
        send(8'h41, 1'b0);
        frame_check("w7_41", 32'({1'b1, 1'b0, 7'h41, 1'b0}), 10, 1);
        sel = 1'b0;

        pm = 2'b00;
        @(negedge clk);
        d8 = 8'h55;
        v8 = 1'b1;
        @(posedge clk);
        #1 d8 = 8'hAA;
        fork
            frame_check("b2b", 32'({1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0}), 20, 2);
            begin
                @(posedge clk);
                #1 chk1("b2b_ready_load1", rdy8, 1'b1);
                @(posedge clk);
                #1 v8 = 1'b0;
                chk1("b2b_ready_acc2", rdy8, 1'b0);
            end
            begin
                @(posedge clk);
                repeat (10) wait_ce();
                #1 chk1("b2b_ready_before_load2", rdy8, 1'b0);
                wait_ce();
                #1 chk1("b2b_ready_load2", rdy8, 1'b1);
            end
        join

        cts = 1'b1;
        send(8'hA5, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk1("cts_hold_txd", txd8, 1'b1);
        chk1("cts_hold_ready", rdy8, 1'b0);
        chk1("cts_hold_busy", busy8, 1'b0);
        chk1("cts_hold_txct", txct8, 1'b1);
        @(negedge clk) cts = 1'b0;
        fork
            frame_check("cts", 32'({1'b1, 8'hA5, 1'b0}), 10, 1);
            begin
                repeat (40) @(posedge clk);
                #1 cts = 1'b1;
            end
        join
        @(negedge clk) cts = 1'b0;

        send(8'h3C, 1'b0);
        @(posedge clk);
        repeat (3) wait_ce();
        send(8'h81, 1'b0);
        @(negedge clk);
        chk1("rstm_ready_full", rdy8, 1'b0);
        chk1("rstm_txct_active", txct8, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk1("rstm_txd", txd8, 1'b1);
        chk1("rstm_txct", txct8, 1'b1);
        chk1("rstm_busy", busy8, 1'b0);
        chk1("rstm_ready", rdy8, 1'b1);
        chk1("rstm_done", done8, 1'b0);
        @(negedge clk) rst = 1'b0;
        dc0 = dc8;
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            #1 if (txd8 !== 1'b1 || busy8 !== 1'b0) bad++;
        end
        chkn("rstm_quiet_cycles", bad, 0);
        chkn("rstm_no_done", dc8 - dc0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/is_uart_tx_param.md
Name: is_uart_tx_param

Overview:
Parametrised UART transmit engine; next generation of the team's fixed 8-bit TX FSM. Serialises DATA_W-bit words LSB-first with run-time selectable parity (none/even/odd) and 1 or 2 stop bits. Adds a one-word holding buffer with valid/ready handshake for gap-free back-to-back frames, and CTS flow control. Sits in the UART controller next to the RX FSM; bit timing comes from the shared baud-rate divider as a one-cycle uart_ce_i strobe per bit period.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9
CNT_W, $clog2(DATA_W), width of the data-bit counter (derived, not overridden)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; synchronous, active-high
uart_ce_i  in  1  bit-period strobe, one clk_i cycle wide
tx_data_i  in  DATA_W  word to send
tx_valid_i  in  1  tx_data_i valid
tx_ready_o  out  1  holding buffer empty; word accepted when valid&ready
parity_mode_i  in  2  parity_mode_t: 00 none, 01 even, 10 odd, 11 treated as none
stop2_i  in  1  1 = two stop bits
cts_n_i  in  1  clear-to-send, active-low
txd_o  out  1  serial line, idle high
txct_r_o  out  1  transmit-control, low while a frame is on the line
tx_busy_o  out  1  high from shifter load until last stop bit ends
tx_done_o  out  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (rst_i=1 at clk_i edge): state IDLE, buffer empty, txd_o=1, txct_r_o=1, tx_busy_o=0, tx_done_o=0; tx_ready_o=1 after reset. Reset mid-frame aborts: line high on next edge, buffered word dropped.
- tx_ready_o = !buf_valid (from register, no combinational path from tx_valid_i). Accept on valid&ready; buf_valid set next edge.
- Load: in IDLE, if buf_valid and cts_n_i=0, copy buffer to shifter, latch parity_mode_i/stop2_i, compute parity over the word, clear buf_valid, tx_busy_o=1, go WCE. Config changes mid-frame have no effect.
- Every state below advances only on a uart_ce_i cycle; otherwise holds. txd_o is registered.
- WCE: on ce, txd_o=0, txct_r_o=0, -> START.
- START: on ce, txd_o=data[0], cnt=0, -> DATA.
- DATA: on ce, if cnt==DATA_W-1: parity on -> txd_o=parity, PARITY; else txd_o=1, STOP1. Otherwise txd_o=next bit, cnt++.
- PARITY: on ce, txd_o=1, -> STOP1. Even: bit = XOR of data; odd: inverted.
- STOP1: on ce, stop2 latched -> STOP2; else frame end.
- STOP2: on ce, frame end.
- Frame end (same ce cycle): tx_done_o=1 for one cycle. If buf_valid and cts_n_i=0: load buffer, txd_o=0 -> START directly (no idle bit, txct_r_o stays 0). Else txd_o=1, txct_r_o=1, tx_busy_o=0, -> IDLE.
- Latency, idle start: word accepted edge N; load at N+1; start bit begins at first uart_ce_i after load.
- Frame length = 1+DATA_W+(parity?1:0)+(stop2?2:1) bit periods.
- cts_n_i sampled only at load points; deassertion mid-frame never truncates a frame.
- uart_ce_i coincident with load cycle is not used by that frame (WCE waits for next strobe).

Decomposition:
- Package is_pkg_uart_controller: add parity_mode_t enum (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD) and tx_state_t enum (TX_IDLE, TX_WCE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2); keep separate from existing state_t.
- Single module; parity computed as reduction in-line, no sub-module needed.

Test Plan:
- DATA_W=8, 8N1, send 0xA5, ce every 16 clk -> txd_o per bit: 0,1,0,1,0,0,1,0,1,1; tx_done_o one pulse; txct_r_o low for exactly 10 bit periods.
- 8O2, send 0xA5 -> 0,1,0,1,0,0,1,0,1, parity 1, stop 1,1 (12 bits); 8E1 same word -> parity 0.
- DATA_W=7, even parity, send 0x41 -> 0,1,0,0,0,0,0,1, parity 0, stop 1; 10 bits total.
- 8N1, tx_valid_i held with 0x55 then 0xAA -> second start bit immediately follows first stop bit, 20 contiguous bit periods, tx_ready_o high again one cycle after each load.
- cts_n_i=1 with word buffered -> txd_o stays 1, tx_ready_o=0; release cts_n_i -> frame starts at next ce; toggle cts_n_i mid-frame -> frame completes unchanged.
- Assert rst_i during DATA of 0x3C with second word buffered -> next edge txd_o=1, txct_r_o=1, tx_busy_o=0, tx_ready_o=1, no further frame emitted.
